// File: rtl/avg_sched_if.sv
// Sample/result bus of the multi-channel two-tap averaging scheduler.
interface avg_sched_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            i_ce;
    logic [NUM_CH*DATA_WIDTH-1:0] i_data;
    logic                         i_flush;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic [CH_W-1:0]              o_ch;
    logic                         o_ce;
    logic [NUM_CH-1:0]            o_overflow;
    logic                         o_busy;

    modport master (
        output i_ce, i_data, i_flush,
        input  data_out, o_ch, o_ce, o_overflow, o_busy
    );

    modport slave (
        input  i_ce, i_data, i_flush,
        output data_out, o_ch, o_ce, o_overflow, o_busy
    );
endinterface

// File: rtl/avg_channel_scheduler.sv
// Round-robin scheduler sharing one y = (x[n] + x[n-1]) >>> 1 pipeline across NUM_CH channels.
// Define AVG_SCHED_ROUNDING_EN to round half toward +inf instead of flooring.
module avg_channel_scheduler #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    avg_sched_if.slave bus
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned SUM_W = DATA_WIDTH + 1;

    logic [NUM_CH-1:0]                 pend_q, pend_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] last_q, last_d;
    logic [NUM_CH-1:0]                 ovf_q, ovf_d;
    logic [CH_W-1:0]                   rr_q, rr_d;
    logic                              s0_v_q, s0_v_d;
    logic [SUM_W-1:0]                  s0_sum_q, s0_sum_d;
    logic [CH_W-1:0]                   s0_ch_q, s0_ch_d;
    logic [DATA_WIDTH-1:0]             dout_q, dout_d;
    logic [CH_W-1:0]                   och_q, och_d;
    logic                              oce_q, oce_d;

    logic                              gnt_v;
    logic [CH_W-1:0]                   gnt_ch;
    logic [CH_W-1:0]                   idx;
    logic [SUM_W-1:0]                  rnd_sum;

`ifdef AVG_SCHED_ROUNDING_EN
    assign rnd_sum = s0_sum_q + SUM_W'(1);
`else
    assign rnd_sum = s0_sum_q;
`endif

    // First pending channel at or after rr_q, wrapping; flush suppresses the grant.
    always_comb begin
        gnt_v  = 1'b0;
        gnt_ch = '0;
        idx    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            idx = CH_W'((32'(rr_q) + 32'(i)) % NUM_CH);
            if (!gnt_v && pend_q[idx]) begin
                gnt_v  = 1'b1;
                gnt_ch = idx;
            end
        end
        if (bus.i_flush) begin
            gnt_v = 1'b0;
        end
    end

    always_comb begin
        pend_d   = pend_q;
        buf_d    = buf_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        rr_d     = rr_q;
        s0_v_d   = 1'b0;
        s0_sum_d = s0_sum_q;
        s0_ch_d  = s0_ch_q;
        dout_d   = dout_q;
        och_d    = och_q;
        oce_d    = s0_v_q;

        if (s0_v_q) begin
            dout_d = DATA_WIDTH'(rnd_sum >> 1);
            och_d  = s0_ch_q;
        end

        if (gnt_v) begin
            s0_v_d   = 1'b1;
            s0_sum_d = {buf_q[gnt_ch][DATA_WIDTH-1], buf_q[gnt_ch]}
                     + {last_q[gnt_ch][DATA_WIDTH-1], last_q[gnt_ch]};
            s0_ch_d  = gnt_ch;
            last_d[gnt_ch] = buf_q[gnt_ch];
            pend_d[gnt_ch] = 1'b0;
            rr_d     = CH_W'((32'(gnt_ch) + 32'd1) % NUM_CH);
        end

        // A slot granted this cycle is already free again, so it may be refilled.
        if (bus.i_flush) begin
            pend_d = '0;
            last_d = '0;
            ovf_d  = '0;
            rr_d   = '0;
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (bus.i_ce[k]) begin
                    if (!pend_d[k]) begin
                        buf_d[k]  = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
                        pend_d[k] = 1'b1;
                    end else begin
                        ovf_d[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= '0;
            buf_q    <= '0;
            last_q   <= '0;
            ovf_q    <= '0;
            rr_q     <= '0;
            s0_v_q   <= 1'b0;
            s0_sum_q <= '0;
            s0_ch_q  <= '0;
            dout_q   <= '0;
            och_q    <= '0;
            oce_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            buf_q    <= buf_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            rr_q     <= rr_d;
            s0_v_q   <= s0_v_d;
            s0_sum_q <= s0_sum_d;
            s0_ch_q  <= s0_ch_d;
            dout_q   <= dout_d;
            och_q    <= och_d;
            oce_q    <= oce_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.o_ch       = och_q;
    assign bus.o_ce       = oce_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_busy     = (|pend_q) | s0_v_q | oce_q;

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Directed bench for avg_channel_scheduler with a per-cycle reference model and literal result checks.
module tb_avg_channel_scheduler;
    localparam int DW = 8;
    localparam int N  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    avg_sched_if #(.DATA_WIDTH(DW), .NUM_CH(N)) bus ();

    avg_channel_scheduler #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_drv    = 0;

    // Reference state
    bit         m_pend [N];
    int         m_buf  [N];
    int         m_last [N];
    int         m_rr   = 0;
    bit [N-1:0] m_ovf  = '0;
    bit         m_p0v  = 0;
    int         m_p0c  = 0;
    int         m_p0d  = 0;
    bit         m_ce   = 0;
    int         m_och  = 0;
    int         m_dout = 0;

    int obs_ch[$], obs_d[$], obs_cyc[$];
    int exp_ch[$], exp_d[$];

    function automatic int avg2(int a, int b);
        int s;
        s = a + b;
`ifdef AVG_SCHED_ROUNDING_EN
        s = s + 1;
`endif
        return (s >= 0) ? s / 2 : -((-s + 1) / 2);
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: one scheduling step per clock
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                m_pend[k] = 0; m_buf[k] = 0; m_last[k] = 0;
            end
            m_rr = 0; m_ovf = '0; m_p0v = 0; m_ce = 0; m_och = 0; m_dout = 0;
        end else begin
            int g;
            m_ce = m_p0v;
            if (m_p0v) begin
                m_dout = m_p0d;
                m_och  = m_p0c;
            end
            g = -1;
            if (!bus.i_flush) begin
                for (int i = 0; i < N; i++)
                    if (g < 0 && m_pend[(m_rr + i) % N]) g = (m_rr + i) % N;
            end
            m_p0v = (g >= 0);
            if (g >= 0) begin
                m_p0d     = avg2(m_buf[g], m_last[g]);
                m_p0c     = g;
                m_last[g] = m_buf[g];
                m_pend[g] = 0;
                m_rr      = (g + 1) % N;
            end
            if (bus.i_flush) begin
                for (int k = 0; k < N; k++) begin
                    m_pend[k] = 0; m_last[k] = 0;
                end
                m_ovf = '0;
                m_rr  = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (bus.i_ce[k]) begin
                        if (!m_pend[k]) begin
                            logic signed [DW-1:0] v;
                            v = bus.i_data[k*DW +: DW];
                            m_buf[k]  = int'(v);
                            m_pend[k] = 1;
                        end else begin
                            m_ovf[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, plus output log for literal checks
    always @(negedge clk) begin
        if (reset_n) begin
            bit busy;
            busy = m_p0v | m_ce;
            for (int k = 0; k < N; k++) busy |= m_pend[k];
            chk("o_ce", int'(bus.o_ce), int'(m_ce));
            chk("data_out", int'(bus.data_out), m_dout);
            chk("o_ch", int'(bus.o_ch), m_och);
            chk("o_overflow", int'(bus.o_overflow), int'(m_ovf));
            chk("o_busy", int'(bus.o_busy), int'(busy));
            if (bus.o_ce) begin
                obs_ch.push_back(int'(bus.o_ch));
                obs_d.push_back(int'(bus.data_out));
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive(bit [N-1:0] ce, logic [N*DW-1:0] d, bit fl);
        @(negedge clk);
        #1;
        bus.i_ce    = ce;
        bus.i_data  = d;
        bus.i_flush = fl;
        t_drv       = cyc;
    endtask

    task automatic put(int ch, int val);
        logic [N*DW-1:0] d;
        bit   [N-1:0]    ce;
        d  = '0;
        ce = '0;
        d[ch*DW +: DW] = DW'(val);
        ce[ch] = 1'b1;
        drive(ce, d, 1'b0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b0);
    endtask

    task automatic ex(int ch, int d);
        exp_ch.push_back(ch);
        exp_d.push_back(d);
    endtask

    task automatic clear_obs();
        obs_ch.delete(); obs_d.delete(); obs_cyc.delete();
        exp_ch.delete(); exp_d.delete();
    endtask

    task automatic verify(string nm);
        chk({nm, "_count"}, obs_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            chk($sformatf("%s_ch%0d", nm, i), obs_ch[i], exp_ch[i]);
            chk($sformatf("%s_d%0d", nm, i), obs_d[i], exp_d[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_o_ce", int'(bus.o_ce), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_o_ch", int'(bus.o_ch), 0);
        chk("rst_o_overflow", int'(bus.o_overflow), 0);
        chk("rst_o_busy", int'(bus.o_busy), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int ta, tb;
        bus.i_ce = '0; bus.i_data = '0; bus.i_flush = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Two samples on ch0 with no contention: 5 then 15, three cycles after each strobe
        clear_obs();
        put(0, 10); ta = t_drv;
        idle(4);
        put(0, 20); tb = t_drv;
        idle(5);
        ex(0, 5); ex(0, 15);
        verify("ch0_seq");
        if (obs_cyc.size() == 2) begin
            chk("lat_first", obs_cyc[0] - ta, 3);
            chk("lat_second", obs_cyc[1] - tb, 3);
        end

        // Negative and extreme values from a clean history
        do_reset();
        clear_obs();
        put(1, -3);   idle(5);
        put(2, 127);  idle(5);
        put(2, 127);  idle(5);
        put(3, -128); idle(5);
        put(3, -128); idle(5);
`ifdef AVG_SCHED_ROUNDING_EN
        ex(1, -1); ex(2, 64);
`else
        ex(1, -2); ex(2, 63);
`endif
        ex(2, 127); ex(3, -64); ex(3, -128);
        verify("extremes");

        // All channels at once: served 0..3 on consecutive cycles
        drive('0, '0, 1'b1);
        idle(1);
        clear_obs();
        drive(4'b1111, {8'd16, 8'd12, 8'd8, 8'd4}, 1'b0);
        idle(7);
        ex(0, 2); ex(1, 4); ex(2, 6); ex(3, 8);
        verify("burst");
        if (obs_cyc.size() == 4) chk("burst_back_to_back", obs_cyc[3] - obs_cyc[0], 3);
        chk("burst_ovf", int'(bus.o_overflow), 0);

        // Held strobes: only the granted ch0 refills, others overflow and stay flagged
        drive('0, '0, 1'b1);
        idle(1);
        clear_obs();
        drive(4'b1111, {8'd16, 8'd12, 8'd8, 8'd4}, 1'b0);
        drive(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
        idle(1);
        chk("held_ovf", int'(bus.o_overflow), 4'b1110);
        idle(8);
        ex(0, 2); ex(1, 4); ex(2, 6); ex(3, 8);
`ifdef AVG_SCHED_ROUNDING_EN
        ex(0, 3);
`else
        ex(0, 2);
`endif
        verify("held");
        chk("held_ovf_sticky", int'(bus.o_overflow), 4'b1110);
        drive('0, '0, 1'b1);
        idle(1);
        chk("flush_ovf", int'(bus.o_overflow), 0);

        // Flush wipes history: 100 -> 50, then 50 -> 25
        clear_obs();
        put(2, 100); idle(5);
        drive('0, '0, 1'b1);
        put(2, 50);  idle(5);
        ex(2, 50); ex(2, 25);
        verify("flush_hist");

        // Reset while a ch3 result is in flight: nothing emerges afterwards
        clear_obs();
        put(3, 40);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_o_ce", int'(bus.o_ce), 0);
        chk("midrst_data_out", int'(bus.data_out), 0);
        chk("midrst_o_busy", int'(bus.o_busy), 0);
        bus.i_ce = '0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        idle(6);
        verify("midrst_silent");
        clear_obs();
        put(3, 40); idle(5);
        ex(3, 20);
        verify("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
